// File: rtl/store_narrow_buffer.sv
// Store-path narrowing unit: narrows a store operand to byte/halfword/word lanes,
// builds byte enables, rejects misaligned stores and buffers legal ones toward memory.
module store_narrow_buffer #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    output logic          st_misaligned,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic [CW-1:0] count,
    output logic [7:0]    err_count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_err;
    logic            r_mis;

    logic            w_legal;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    logic            w_full, w_empty, w_hs, w_push, w_pop;
    entry_t          w_entry;

    always_comb begin
        w_legal = 1'b0;
        w_wdata = st_data;
        w_be    = 4'b0000;
        case (st_size)
            2'b00: begin
                w_legal = 1'b1;
                w_wdata = {4{st_data[7:0]}};
                w_be    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                w_legal = ~st_addr[0];
                w_wdata = {2{st_data[15:0]}};
                w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_legal = (st_addr[1:0] == 2'b00);
                w_wdata = st_data;
                w_be    = 4'b1111;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // st_ready depends only on registered occupancy, so no path from mem_ready.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_hs    = st_valid && !w_full;
    assign w_push  = w_hs && w_legal;
    assign w_pop   = !w_empty && mem_ready;
    assign w_entry = '{addr: {st_addr[31:2], 2'b00}, wdata: w_wdata, be: w_be};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
            r_mis <= 1'b0;
        end else begin
            r_mis <= w_hs && !w_legal;
            if (w_hs && !w_legal && r_err != 8'hFF) r_err <= r_err + 8'd1;
        end
    end

    assign st_ready      = !w_full;
    assign mem_valid     = !w_empty;
    assign mem_addr      = r_mem[r_rptr].addr;
    assign mem_wdata     = r_mem[r_rptr].wdata;
    assign mem_be        = r_mem[r_rptr].be;
    assign count         = r_count;
    assign err_count     = r_err;
    assign st_misaligned = r_mis;
endmodule

// File: tb/tb_store_narrow_buffer.sv
// Self-checking bench for store_narrow_buffer: directed test-plan steps plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_store_narrow_buffer;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_size;
    logic          st_misaligned;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [CW-1:0] count;
    logic [7:0]    err_count;

    store_narrow_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .st_misaligned(st_misaligned),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .count(count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    int   m_err;
    bit   m_mis;
    int   errs = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Spec rules expressed arithmetically: replication by multiplication, lane by shift.
    function automatic void narrow(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] sz, output bit legal,
                                   output logic [31:0] wd, output logic [3:0] be);
        int off;
        off   = int'(a % 4);
        legal = 0;
        wd    = 0;
        be    = 0;
        if (sz == 2'd0) begin
            legal = 1;
            wd    = (d & 32'hFF) * 32'h01010101;
            be    = 4'(1 << off);
        end else if (sz == 2'd1) begin
            legal = (off % 2) == 0;
            wd    = (d & 32'hFFFF) * 32'h00010001;
            be    = 4'(3 << (off & 2));
        end else if (sz == 2'd2) begin
            legal = off == 0;
            wd    = d;
            be    = 4'hF;
        end
    endfunction

    // Check DUT against model at the negative edge, then advance the model across the next rising edge.
    task automatic step();
        bit exp_ready, hs, pop, legal;
        logic [31:0] wd;
        logic [3:0]  be;
        ent_t e;
        @(negedge clk);
        exp_ready = q.size() < DEPTH;
        chk("st_ready", 32'(st_ready), 32'(exp_ready));
        chk("mem_valid", 32'(mem_valid), 32'(q.size() > 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("st_misaligned", 32'(st_misaligned), 32'(m_mis));
        if (q.size() > 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("mem_be", 32'(mem_be), 32'(q[0].be));
        end
        hs  = st_valid && exp_ready;
        pop = (q.size() > 0) && mem_ready;
        narrow(st_addr, st_data, st_size, legal, wd, be);
        if (pop) void'(q.pop_front());
        if (hs && legal) begin
            e.addr  = st_addr & 32'hFFFF_FFFC;
            e.wdata = wd;
            e.be    = be;
            q.push_back(e);
        end
        m_mis = hs && !legal;
        if (hs && !legal && m_err < 255) m_err++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        drive(0, 0, 0, 0);
        m_err = 0;
        m_mis = 0;
        #12;
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_mis", 32'(st_misaligned), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte store
        mem_ready = 1'b1;
        drive(1, 32'h1003, 32'hDEADBEEF, 2'd0);
        step();
        drive(0, 0, 0, 0);
        chk("byte_valid", 32'(mem_valid), 1);
        chk("byte_addr", mem_addr, 32'h1000);
        chk("byte_wdata", mem_wdata, 32'hEFEFEFEF);
        chk("byte_be", 32'(mem_be), 32'h8);
        step();
        chk("byte_drained", 32'(count), 0);

        // Halfword and word narrowing
        drive(1, 32'h2002, 32'h1234ABCD, 2'd1);
        step();
        drive(0, 0, 0, 0);
        chk("half_wdata", mem_wdata, 32'hABCDABCD);
        chk("half_be", 32'(mem_be), 32'hC);
        step();
        drive(1, 32'h3000, 32'hCAFEF00D, 2'd2);
        step();
        drive(0, 0, 0, 0);
        chk("word_wdata", mem_wdata, 32'hCAFEF00D);
        chk("word_be", 32'(mem_be), 32'hF);
        step();

        // Misalignment: three illegal handshakes back to back
        drive(1, 32'h2001, 32'h1, 2'd1);
        step();
        chk("mis1", 32'(st_misaligned), 1);
        drive(1, 32'h3002, 32'h2, 2'd2);
        step();
        chk("mis2", 32'(st_misaligned), 1);
        drive(1, 32'h0, 32'h3, 2'd3);
        step();
        chk("mis3", 32'(st_misaligned), 1);
        drive(0, 0, 0, 0);
        step();
        chk("mis_end", 32'(st_misaligned), 0);
        chk("mis_err3", 32'(err_count), 3);
        chk("mis_count0", 32'(count), 0);

        // Back-pressure: A, B fill the FIFO, C is withheld
        mem_ready = 1'b0;
        drive(1, 32'hA0, 32'h11, 2'd0);
        step();
        drive(1, 32'hB4, 32'h22, 2'd0);
        step();
        drive(1, 32'hC8, 32'h33, 2'd0);
        chk("full_ready0", 32'(st_ready), 0);
        step();
        step();
        chk("full_hold_addr", mem_addr, 32'hA0);
        chk("full_count", 32'(count), 2);
        mem_ready = 1'b1;
        step();
        chk("drain_B", mem_addr, 32'hB4);
        step();
        chk("drain_C", mem_addr, 32'hC8);
        drive(0, 0, 0, 0);
        step();

        // Simultaneous push/pop across pointer wrap
        mem_ready = 1'b0;
        drive(1, 32'h400, 32'h55, 2'd0);
        step();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h500 + 32'(i), 32'(i * 7 + 1), 2'd0);
            step();
            chk("stream_count1", 32'(count), 1);
        end
        drive(0, 0, 0, 0);
        step();
        step();

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom_range(0, 3)));
            mem_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        drive(0, 0, 0, 0);
        mem_ready = 1'b1;
        step();
        step();
        step();

        // Saturation of err_count
        for (int i = 0; i < 300; i++) begin
            drive(1, 32'h1 + 32'($urandom_range(0, 3) * 4), $urandom, 2'($urandom_range(1, 3)));
            step();
        end
        drive(0, 0, 0, 0);
        step();
        chk("err_sat", 32'(err_count), 255);

        // Reset mid-drain, asserted between clock edges
        mem_ready = 1'b0;
        drive(1, 32'h600, 32'h77, 2'd2);
        step();
        drive(1, 32'h604, 32'h88, 2'd2);
        step();
        drive(0, 0, 0, 0);
        chk("pre_rst_count", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(mem_valid), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_ready", 32'(st_ready), 1);
        chk("midrst_err", 32'(err_count), 0);
        q.delete();
        m_err = 0;
        m_mis = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        chk("post_rst_valid", 32'(mem_valid), 0);
        chk("post_rst_addr", mem_addr, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/store_narrow_buffer.md
# store_narrow_buffer

Store-path narrowing unit between the register-file read port and data memory, the write-direction counterpart of the load-path immediate/data extender. It narrows a 32-bit store operand to byte or halfword lanes, generates byte enables, and flags misaligned or illegal-size stores. Accepted stores are buffered in a small FIFO and drained to data memory over a valid/ready handshake, so memory back-pressure never corrupts a store.

## Interface
- DEPTH, 2, FIFO entries; power of two, at least 2
- CW, $clog2(DEPTH)+1, width of `count`
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- st_valid  input  1  store request valid
- st_ready  output  1  request accepted when high together with st_valid; equals !full
- st_addr  input  32  byte address
- st_data  input  32  register operand; the low bits hold the value
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- st_misaligned  output  1  one-cycle error pulse, registered
- mem_valid  output  1  head entry valid; equals !empty
- mem_ready  input  1  memory accepts the head entry
- mem_addr  output  32  word address {st_addr[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated write data
- mem_be  output  4  byte enables; bit i enables bits [8i+7:8i]
- count  output  CW  current occupancy, 0..DEPTH
- err_count  output  8  saturating count of rejected stores

## Operation
- A handshake happens when st_valid && st_ready.
- Each handshake is classified as legal or illegal:
  - byte: always legal.
  - halfword: legal iff st_addr[0]==0.
  - word: legal iff st_addr[1:0]==0.
  - size 11: always illegal.
- A legal handshake pushes {mem_addr, mem_wdata, mem_be}.
- An illegal handshake is consumed without a push. It drives st_misaligned high on the next cycle for exactly one cycle and increments err_count, saturating at 255.
- Narrowing rules:
  - byte: wdata = {4{st_data[7:0]}}, be = 4'b0001 << st_addr[1:0].
  - halfword: wdata = {2{st_data[15:0]}}, be = st_addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata = st_data, be = 4'b1111.
- The upper bits of st_data beyond the selected size are ignored (truncation, no checking).
- Pop happens when mem_valid && mem_ready. The mem_* outputs always present the head entry.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count changes as follows:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
- Full (count==DEPTH) drives st_ready low. There is no bypass: a pop in the same cycle does not allow a push while full.
- Empty (count==0) drives mem_valid low. Push and pop cannot both occur while empty.

## Timing
- Reset, asynchronous on rst_n low:
  - pointers = 0, count = 0, err_count = 0, st_misaligned = 0.
  - All storage cleared, so mem_addr = 0, mem_wdata = 0, mem_be = 0.
  - mem_valid = 0, st_ready = 1.
- Reset mid-operation discards all buffered stores immediately. Memory must ignore mem_* while rst_n is low.
- Latency: a store accepted at edge N is visible on mem_* after edge N when the FIFO was empty. Otherwise it becomes visible after the pops of the earlier entries.
- There is no combinational path from st_* to mem_*.
- There is no combinational path from mem_ready to st_ready.
- While mem_valid && !mem_ready, mem_addr, mem_wdata and mem_be hold stable.
- st_misaligned asserts the cycle after the illegal handshake.
- Back-to-back illegal handshakes keep st_misaligned high for consecutive cycles, and err_count increments once per handshake.
- Throughput: one push and one pop per cycle in steady state when not full.

## Test plan
- **Reset and single byte store:** reset, then byte store addr 0x1003, data 0xDEADBEEF with mem_ready=1. Required next cycle: mem_valid=1, mem_addr=0x1000, mem_wdata=0xEFEFEFEF, mem_be=4'b1000. Required the cycle after: count returns to 0.
- **Halfword and word narrowing:**
  - half at 0x2002, data 0x1234ABCD -> wdata 0xABCDABCD, be 4'b1100.
  - word at 0x3000 -> wdata = data, be 4'b1111.
- **Misalignment:** half at 0x2001, word at 0x3002, then size 11 at 0x0. Required: no pushes; st_misaligned high for 3 consecutive cycles; err_count=3; count stays 0.
- **Back-pressure and full:** hold mem_ready=0 and push 3 legal stores with DEPTH=2. Required:
  - The 3rd handshake is withheld (st_ready=0 once count=2).
  - mem_* stay stable on the first store.
  - After mem_ready=1, stores drain in order A, B, then C is accepted.
- **Simultaneous push/pop and wrap:**
  - With count=1 and mem_ready=1, stream 10 consecutive byte stores. Required: count stays at 1, order preserved across pointer wrap.
  - Separately, err_count saturates at 255 after 300 illegal stores.
- **Reset mid-drain:** with count=2 and mem_ready=0, assert rst_n low asynchronously between clock edges. Required: mem_valid=0, count=0 and st_ready=1 immediately, and no stale entry reappears after release.
